// File: rtl/msrv32_branch_predict_unit.sv
// Branch predictor and resolver: 2-bit BHT prediction at fetch,
// registered branch resolution, BHT training and perf counters at execute.
module msrv32_branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         PERF_W      = 16
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0]   fetch_pc_in,
  output logic              predict_taken_out,
  input  logic              resolve_valid_in,
  input  logic [XLEN-1:0]   resolve_pc_in,
  input  logic [4:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   rs1_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic              predicted_taken_in,
  input  logic              flush_in,
  output logic              resolve_valid_out,
  output logic              branch_taken_out,
  output logic              mispredict_out,
  output logic [PERF_W-1:0] branch_count_out,
  output logic [PERF_W-1:0] mispredict_count_out
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  logic [1:0]        r_bht [BHT_ENTRIES];
  logic              r_valid;
  logic              r_taken;
  logic              r_mis;
  logic [PERF_W-1:0] r_br_cnt;
  logic [PERF_W-1:0] r_mis_cnt;

  logic [IDX_W-1:0]  w_fidx;
  logic [IDX_W-1:0]  w_ridx;
  logic              w_accept;
  logic              w_is_br;
  logic              w_is_jmp;
  logic              w_taken;
  logic              w_mis;
  logic [1:0]        w_ctr;
  logic [1:0]        w_ctr_nxt;
  logic              w_unused;

  assign w_fidx   = fetch_pc_in[IDX_W+1:2];
  assign w_ridx   = resolve_pc_in[IDX_W+1:2];
  assign w_accept = resolve_valid_in & ~flush_in;
  assign w_is_br  = (opcode_in == OP_BR);
  assign w_is_jmp = (opcode_in == OP_JAL) | (opcode_in == OP_JALR);
  assign w_mis    = w_taken ^ predicted_taken_in;
  assign w_ctr    = r_bht[w_ridx];

  // High PC bits alias by design; low two bits are always 0 for aligned PCs.
  assign w_unused = ^{fetch_pc_in[XLEN-1:IDX_W+2], fetch_pc_in[1:0],
                      resolve_pc_in[XLEN-1:IDX_W+2], resolve_pc_in[1:0]};

  // Prediction reads the stored counter only; updates show next cycle.
  assign predict_taken_out    = r_bht[w_fidx][1];
  assign resolve_valid_out    = r_valid;
  assign branch_taken_out     = r_taken;
  assign mispredict_out       = r_mis;
  assign branch_count_out     = r_br_cnt;
  assign mispredict_count_out = r_mis_cnt;

  // Actual taken decision for the presented instruction.
  always_comb begin
    w_taken = 1'b0;
    unique case (1'b1)
      w_is_br: begin
        case (funct3_in)
          3'b000:  w_taken = (rs1_in == rs2_in);
          3'b001:  w_taken = (rs1_in != rs2_in);
          3'b100:  w_taken = ($signed(rs1_in) < $signed(rs2_in));
          3'b101:  w_taken = ($signed(rs1_in) >= $signed(rs2_in));
          3'b110:  w_taken = (rs1_in < rs2_in);
          3'b111:  w_taken = (rs1_in >= rs2_in);
          default: w_taken = 1'b0;
        endcase
      end
      w_is_jmp: w_taken = 1'b1;
      default:  w_taken = 1'b0;
    endcase
  end

  // Saturating 2-bit counter step for the resolving index.
  always_comb begin
    w_ctr_nxt = w_ctr;
    if (w_taken) begin
      if (w_ctr != 2'b11) w_ctr_nxt = w_ctr + 2'd1;
    end else begin
      if (w_ctr != 2'b00) w_ctr_nxt = w_ctr - 2'd1;
    end
  end

  // Result registers; taken/mispredict hold when nothing is accepted.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_taken <= w_taken;
        r_mis   <= w_mis;
      end
    end
  end

  // BHT training, conditional branches only.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (w_accept && w_is_br) begin
      r_bht[w_ridx] <= w_ctr_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_accept) begin
      if (w_is_br && r_br_cnt != '1)
        r_br_cnt <= r_br_cnt + PERF_W'(1);
      if (w_mis && r_mis_cnt != '1)
        r_mis_cnt <= r_mis_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_msrv32_branch_predict_unit.sv
// Scoreboard bench for msrv32_branch_predict_unit:
// directed requests push expected results, a monitor pops on valid.
module tb_msrv32_branch_predict_unit;

  localparam int XLEN = 32;
  localparam int PW   = 4;
  localparam logic [4:0] BR   = 5'b11000;
  localparam logic [4:0] JAL  = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;
  localparam logic [4:0] OPI  = 5'b00100;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken_out;
  logic            resolve_valid_in;
  logic [XLEN-1:0] resolve_pc;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            pred_in;
  logic            flush;
  logic            resolve_valid_out;
  logic            branch_taken_out;
  logic            mispredict_out;
  logic [PW-1:0]   branch_count_out;
  logic [PW-1:0]   mispredict_count_out;

  int total = 0;
  int bad   = 0;
  int exp_br  = 0;
  int exp_mis = 0;
  logic [1:0] q[$];

  msrv32_branch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(64), .CTR_INIT(2'b01), .PERF_W(PW)
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .fetch_pc_in          (fetch_pc),
    .predict_taken_out    (predict_taken_out),
    .resolve_valid_in     (resolve_valid_in),
    .resolve_pc_in        (resolve_pc),
    .opcode_in            (opcode),
    .funct3_in            (funct3),
    .rs1_in               (rs1),
    .rs2_in               (rs2),
    .predicted_taken_in   (pred_in),
    .flush_in             (flush),
    .resolve_valid_out    (resolve_valid_out),
    .branch_taken_out     (branch_taken_out),
    .mispredict_out       (mispredict_out),
    .branch_count_out     (branch_count_out),
    .mispredict_count_out (mispredict_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every valid result must match the oldest expectation.
  always @(negedge clk) begin
    logic [1:0] e;
    if (resolve_valid_out === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=valid required=idle");
      end else begin
        e = q.pop_front();
        chk("taken", {31'd0, branch_taken_out}, {31'd0, e[1]});
        chk("mispredict", {31'd0, mispredict_out}, {31'd0, e[0]});
      end
    end
  end

  function automatic int sat(int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic drive(input logic [4:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic pr,
                       input logic fl, input logic et, input logic em);
    opcode = op; funct3 = f3; resolve_pc = pc;
    rs1 = a; rs2 = b; pred_in = pr; flush = fl;
    resolve_valid_in = 1'b1;
    if (!fl && !rst) begin
      q.push_back({et, em});
      if (op == BR) exp_br = sat(exp_br);
      if (em) exp_mis = sat(exp_mis);
    end
  endtask

  task automatic finish_req();
    @(posedge clk);
    @(negedge clk);
    resolve_valid_in = 1'b0;
    flush = 1'b0;
  endtask

  task automatic req(input logic [4:0] op, input logic [2:0] f3,
                     input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] b, input logic pr,
                     input logic et, input logic em);
    drive(op, f3, pc, a, b, pr, 1'b0, et, em);
    finish_req();
  endtask

  task automatic pred(string nm, input logic [31:0] pc, input logic e);
    fetch_pc = pc;
    #1;
    chk(nm, {31'd0, predict_taken_out}, {31'd0, e});
  endtask

  task automatic cnts(string nm);
    chk({nm, "_br"}, {28'd0, branch_count_out}, exp_br);
    chk({nm, "_mis"}, {28'd0, mispredict_count_out}, exp_mis);
  endtask

  initial begin
    rst = 1'b1; fetch_pc = '0; resolve_valid_in = 1'b0;
    resolve_pc = '0; opcode = '0; funct3 = '0;
    rs1 = '0; rs2 = '0; pred_in = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    pred("rst_pred_100", 32'h100, 1'b0);
    pred("rst_pred_0", 32'h0, 1'b0);
    chk("rst_valid", {31'd0, resolve_valid_out}, 0);
    cnts("rst");

    // BEQ training at 0x100: 01->10->11->11
    req(BR, 3'b000, 32'h100, 5, 5, 1'b0, 1'b1, 1'b1);
    pred("beq1_pred", 32'h100, 1'b1);
    req(BR, 3'b000, 32'h100, 5, 5, 1'b0, 1'b1, 1'b1);
    req(BR, 3'b000, 32'h100, 5, 5, 1'b0, 1'b1, 1'b1);
    pred("beq3_pred", 32'h100, 1'b1);
    pred("alias_pred", 32'h1100, 1'b1);
    pred("other_pred", 32'h104, 1'b0);
    chk("beq3_brcnt", {28'd0, branch_count_out}, 3);
    // Not-taken BNE: 11->10->01 proves saturation at 11
    req(BR, 3'b001, 32'h100, 5, 5, 1'b1, 1'b0, 1'b1);
    pred("bne1_pred", 32'h100, 1'b1);
    req(BR, 3'b001, 32'h100, 5, 5, 1'b1, 1'b0, 1'b1);
    pred("bne2_pred", 32'h100, 1'b0);
    cnts("bne");

    // Signed vs unsigned compares, back to back
    drive(BR, 3'b100, 32'h208, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    finish_req();
    drive(BR, 3'b110, 32'h208, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_req();
    req(BR, 3'b101, 32'h208, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b0);
    req(BR, 3'b111, 32'h208, 32'hFFFF_FFFF, 1, 1'b1, 1'b1, 1'b0);
    pred("cmp_pred", 32'h208, 1'b0);
    // funct3 010 is not taken but still trains 01->00
    req(BR, 3'b010, 32'h30C, 7, 9, 1'b0, 1'b0, 1'b0);
    req(BR, 3'b000, 32'h30C, 7, 7, 1'b0, 1'b1, 1'b1);
    pred("f3_010_pred", 32'h30C, 1'b0);
    cnts("cmp");

    // JAL / JALR: always taken, never train the BHT
    req(JAL, 3'b000, 32'h410, 0, 0, 1'b0, 1'b1, 1'b1);
    req(JALR, 3'b000, 32'h410, 0, 0, 1'b1, 1'b1, 1'b0);
    pred("jal_pred", 32'h410, 1'b0);
    cnts("jal");

    // ADDI predicted taken is a misprediction
    req(OPI, 3'b000, 32'h514, 1, 2, 1'b1, 1'b0, 1'b1);
    cnts("addi");

    // Flush kills the request
    drive(BR, 3'b000, 32'h100, 5, 5, 1'b0, 1'b1, 1'b1, 1'b1);
    finish_req();
    chk("flush_valid", {31'd0, resolve_valid_out}, 0);
    chk("hold_taken", {31'd0, branch_taken_out}, 0);
    chk("hold_mis", {31'd0, mispredict_out}, 1);
    pred("flush_pred", 32'h100, 1'b0);
    cnts("flush");

    // Same-index fetch and update: old value now, new value next cycle
    drive(BR, 3'b000, 32'h100, 5, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    pred("coll_old", 32'h100, 1'b0);
    finish_req();
    pred("coll_new", 32'h100, 1'b1);

    // Saturate both perf counters
    for (int i = 0; i < 5; i++)
      req(BR, 3'b000, 32'h618, 3, 3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      req(OPI, 3'b000, 32'h514, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("sat_br", {28'd0, branch_count_out}, 32'hF);
    chk("sat_mis", {28'd0, mispredict_count_out}, 32'hF);
    pred("sat_pred", 32'h618, 1'b1);

    // Reset wins over a concurrent request
    rst = 1'b1;
    drive(BR, 3'b000, 32'h104, 5, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    finish_req();
    rst = 1'b0;
    exp_br = 0;
    exp_mis = 0;
    chk("rst2_valid", {31'd0, resolve_valid_out}, 0);
    chk("rst2_mis", {31'd0, mispredict_out}, 0);
    cnts("rst2");
    pred("rst2_pred_100", 32'h100, 1'b0);
    pred("rst2_pred_618", 32'h618, 1'b0);
    pred("rst2_pred_104", 32'h104, 1'b0);

    // Normal operation after reset
    req(BR, 3'b000, 32'h100, 5, 5, 1'b0, 1'b1, 1'b1);
    cnts("post");

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
